// File: rtl/trng_word_packer.sv
// -----------------------------------------------------------------------------
// trng_word_packer
//
// Takes a raw TRNG bit stream and decimates it (one sample every DECIM enabled
// cycles). It packs WORD_W samples MSB-first into a word and buffers the words
// in a first-word-fall-through FIFO that has a valid/ready output.
//
// A completed word that finds the FIFO full is dropped, not overwritten. The
// loss is counted in a saturating drop counter.
//
// Optional build macro:
//   TRNG_VN_DEBIAS_EN - von Neumann debiasing of the decimated samples.
//                       Samples form non-overlapping pairs (a,b):
//                         01 -> emit 0
//                         10 -> emit 1
//                         00, 11 -> emit nothing
//                       Only emitted bits reach the packer.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset, synchronous release
//   en        sampling enable; low freezes decimator, debiaser and packer
//   bit_in    raw TRNG bit, sampled on clk
//   m_data    head-of-FIFO word (forced to 0 while m_valid is low)
//   m_valid   FIFO non-empty
//   m_ready   sink accepts the head word
//   fill      number of words currently held (0..DEPTH)
//   drop_cnt  number of words dropped on a full FIFO, saturating
// -----------------------------------------------------------------------------
module trng_word_packer #(
  parameter int WORD_W = 8,
  parameter int DECIM  = 1,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     bit_in,
  output logic [WORD_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int BW = $clog2(WORD_W);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  // ---------------------------------------------------------------------------
  // Decimator: the strobe fires on the DECIM-th enabled cycle.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] dcnt_q;
  logic          smp;

  assign smp = en && (dcnt_q == DW'(DECIM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q <= '0;
    end else if (en) begin
      if (smp) dcnt_q <= '0;
      else     dcnt_q <= dcnt_q + DW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Bit source for the packer: either raw decimated samples or debiased pairs.
  // ---------------------------------------------------------------------------
  logic pk_stb;
  logic pk_bit;

`ifdef TRNG_VN_DEBIAS_EN
  // vn_phase_q=1 means the first sample of a pair is held in vn_a_q.
  // The emitted bit of an unequal pair equals its first sample.
  logic vn_phase_q;
  logic vn_a_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vn_phase_q <= 1'b0;
      vn_a_q     <= 1'b0;
    end else if (smp) begin
      vn_phase_q <= ~vn_phase_q;
      if (!vn_phase_q) vn_a_q <= bit_in;
    end
  end

  assign pk_stb = smp && vn_phase_q && (vn_a_q != bit_in);
  assign pk_bit = vn_a_q;
`else
  assign pk_stb = smp;
  assign pk_bit = bit_in;
`endif

  // ---------------------------------------------------------------------------
  // Packer: shift_q holds the WORD_W-1 bits collected so far. The completing
  // bit is spliced in combinationally, so the word is offered on the same edge.
  // ---------------------------------------------------------------------------
  logic [WORD_W-2:0] shift_q;
  logic [BW-1:0]     bcnt_q;
  logic              word_done;
  logic [WORD_W-1:0] word_data;

  assign word_data = {shift_q, pk_bit};
  assign word_done = pk_stb && (bcnt_q == BW'(WORD_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bcnt_q  <= '0;
    end else if (pk_stb) begin
      shift_q <= word_data[WORD_W-2:0];
      if (word_done) bcnt_q <= '0;
      else           bcnt_q <= bcnt_q + BW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT FIFO.
  // Handshake: a word transfers on a rising clk edge where m_valid and m_ready
  // are both high. m_valid never depends on m_ready. m_data is stable while
  // m_valid is high and no transfer has occurred.
  // A push into a full FIFO is accepted only when a pop frees the slot on the
  // same edge; otherwise the word is dropped.
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [FW-1:0]     fill_q;
  logic [CNT_W-1:0]  drop_q;
  logic              pop;
  logic              push;
  logic              drop;

  assign m_valid = (fill_q != '0);
  assign pop     = m_valid && m_ready;
  assign push    = word_done && ((fill_q < FW'(DEPTH)) || pop);
  assign drop    = word_done && !push;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= word_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase
      if (drop && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign m_data   = m_valid ? mem[rd_ptr_q] : '0;
  assign fill     = fill_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_trng_word_packer.sv
// -----------------------------------------------------------------------------
// tb_trng_word_packer
//
// Two instances share clk/rst_n:
//   a: WORD_W=8, DECIM=1, DEPTH=4  (packing, FIFO full/drop, reset)
//   b: WORD_W=8, DECIM=4, DEPTH=16 (decimation with an enable gap)
// Inputs change on the falling edge. Outputs are observed 1 ns later.
// -----------------------------------------------------------------------------
module tb_trng_word_packer;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  logic        a_en = 1'b0, a_bit = 1'b0, a_ready = 1'b0;
  logic [7:0]  a_data;
  logic        a_valid;
  logic [2:0]  a_fill;
  logic [15:0] a_drop;

  logic        b_en = 1'b0, b_bit = 1'b0, b_ready = 1'b0;
  logic [7:0]  b_data;
  logic        b_valid;
  logic [4:0]  b_fill;
  logic [15:0] b_drop;

  trng_word_packer #(.WORD_W(8), .DECIM(1), .DEPTH(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .bit_in(a_bit),
    .m_data(a_data), .m_valid(a_valid), .m_ready(a_ready),
    .fill(a_fill), .drop_cnt(a_drop)
  );

  trng_word_packer #(.WORD_W(8), .DECIM(4), .DEPTH(16), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .bit_in(b_bit),
    .m_data(b_data), .m_valid(b_valid), .m_ready(b_ready),
    .fill(b_fill), .drop_cnt(b_drop)
  );

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b_q[$];

  // Reference model of instance a (DECIM=1, DEPTH=4), non-debias build.
  int         mdl_bcnt = 0;
  int         mdl_fill = 0;
  int         mdl_drop = 0;
  logic [7:0] mdl_word = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ae, input logic ab, input logic ar,
                       input logic be, input logic bb, input logic br);
    @(negedge clk);
    a_en = ae; a_bit = ab; a_ready = ar;
    b_en = be; b_bit = bb; b_ready = br;
    #1;
  endtask

  // One cycle on instance a, checked against the model.
  task automatic cycle_a(input logic ae, input logic ab, input logic ar);
    logic       pop_m;
    logic [7:0] e;
    drive(ae, ab, ar, 1'b0, 1'b0, 1'b0);
    chk("a_valid", {31'd0, a_valid}, {31'd0, (mdl_fill != 0)});
    chk("a_fill", {29'd0, a_fill}, mdl_fill);
    chk("a_drop", {16'd0, a_drop}, mdl_drop);
    pop_m = ar && (mdl_fill != 0);
    if (pop_m) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      chk("a_data", {24'd0, a_data}, {24'd0, e});
    end
    if (ae) begin
      mdl_word = {mdl_word[6:0], ab};
      if (mdl_bcnt == 7) begin
        mdl_bcnt = 0;
        if (mdl_fill < 4 || pop_m) begin
          exp_q.push_back(mdl_word);
          mdl_fill++;
        end else if (mdl_drop != 65535) begin
          mdl_drop++;
        end
      end else begin
        mdl_bcnt++;
      end
    end
    if (pop_m) mdl_fill--;
  endtask

  // MSB first. m_ready is high only while the last bit is presented.
  task automatic send_a(input logic [7:0] w, input logic ready_last);
    for (int i = 7; i >= 0; i--) cycle_a(1'b1, w[i], (i == 0) ? ready_last : 1'b0);
  endtask

  task automatic drain_a();
    for (int k = 0; k < 20 && mdl_fill != 0; k++) cycle_a(1'b0, 1'b0, 1'b1);
    cycle_a(1'b0, 1'b0, 1'b0);
    chk("a_sb_empty", exp_q.size(), 0);
  endtask

  task automatic model_reset();
    mdl_bcnt = 0; mdl_fill = 0; mdl_drop = 0; mdl_word = 8'h00;
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] w;
    logic [7:0] e;
    repeat (3) @(negedge clk);
    chk("rst_a_valid", {31'd0, a_valid}, 0);
    chk("rst_a_data",  {24'd0, a_data}, 0);
    chk("rst_a_fill",  {29'd0, a_fill}, 0);
    chk("rst_a_drop",  {16'd0, a_drop}, 0);
    chk("rst_b_valid", {31'd0, b_valid}, 0);
    rst_n = 1'b1;

`ifdef TRNG_VN_DEBIAS_EN
    // Pairs 10,01,11,10,00,01,10,10,01,10 give emitted bits 10101101 = 0xAD.
    begin
      logic [19:0] pairs;
      pairs = 20'b10_01_11_10_00_01_10_10_01_10;
      for (int i = 19; i >= 0; i--) begin
        drive(1'b1, pairs[i], 1'b0, 1'b0, 1'b0, 1'b0);
        chk("vn_no_early_word", {31'd0, a_valid}, 0);
      end
      exp_q.push_back(8'hAD);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("vn_valid", {31'd0, a_valid}, 1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      chk("vn_data", {24'd0, a_data}, {24'd0, e});
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("vn_fill_after_pop", {29'd0, a_fill}, 0);
    end
`else
    // Basic word 0xB2 with m_ready high throughout.
    w = 8'hB2;
    for (int i = 7; i >= 0; i--) cycle_a(1'b1, w[i], 1'b1);
    // Observed right after the 8th bit: the word must not be visible yet.
    chk("t2_not_yet", {31'd0, a_valid}, 0);
    cycle_a(1'b0, 1'b0, 1'b1);   // visible one cycle later, then popped
    cycle_a(1'b0, 1'b0, 1'b0);
    chk("t2_fill_zero", {29'd0, a_fill}, 0);

    // DECIM=4 on instance b. Filler bits sit between strobes, and an en-low
    // gap is placed in the middle of one decimation period.
    w = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      for (int k = 0; k < 3; k++) begin
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        if (i == 3 && k == 1)
          for (int g = 0; g < 5; g++)
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, w[i], 1'b0);
    end
    exp_b_q.push_back(8'hB2);
    chk("t3_not_yet", {31'd0, b_valid}, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_valid", {31'd0, b_valid}, 1);
    chk("t3_fill", {27'd0, b_fill}, 1);
    e = (exp_b_q.size() != 0) ? exp_b_q.pop_front() : 8'hxx;
    chk("t3_data", {24'd0, b_data}, {24'd0, e});
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_fill_after_pop", {27'd0, b_fill}, 0);
    chk("t3_drop", {16'd0, b_drop}, 0);

    // Six words into a depth-4 FIFO with no sink.
    for (int k = 1; k <= 6; k++) send_a(8'(k), 1'b0);
    cycle_a(1'b0, 1'b0, 1'b0);
    chk("t4_fill", {29'd0, a_fill}, 4);
    chk("t4_drop", {16'd0, a_drop}, 2);

    // Full FIFO, sink ready on the completing edge: push and pop together.
    send_a(8'h07, 1'b1);
    cycle_a(1'b0, 1'b0, 1'b0);
    chk("t5_fill", {29'd0, a_fill}, 4);
    chk("t5_drop", {16'd0, a_drop}, 2);
    drain_a();                     // expected drain order: 02, 03, 04, 07

    // Reset mid-word with three words buffered.
    send_a(8'h11, 1'b0);
    send_a(8'h22, 1'b0);
    send_a(8'h33, 1'b0);
    cycle_a(1'b1, 1'b1, 1'b0);
    cycle_a(1'b1, 1'b0, 1'b0);
    cycle_a(1'b1, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    a_en = 1'b0;
    #1;
    chk("t1_valid", {31'd0, a_valid}, 0);
    chk("t1_fill",  {29'd0, a_fill}, 0);
    chk("t1_drop",  {16'd0, a_drop}, 0);
    chk("t1_data",  {24'd0, a_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send_a(8'h5A, 1'b0);           // must be built only from fresh bits
    drain_a();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests_run=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
